// File: rtl/rx_packet_reader_pkg.sv
// Shared definitions for the RX packet reader: header length field, packet
// geometry, FSM state encoding and the byte-to-word payload length helper.
package rx_packet_reader_pkg;

    localparam int LEN_LSB           = 0;
    localparam int LEN_WIDTH         = 9;
    localparam int PKT_WORDS         = 256;
    localparam int HDR_WORDS         = 4;
    localparam int MAX_PAYLOAD_WORDS = PKT_WORDS - HDR_WORDS;
    localparam int IDLE_GAP          = 2;
    localparam int WCNT_W            = $clog2(PKT_WORDS);
    localparam int GAP_W             = $clog2(IDLE_GAP + 1);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] HDR     = 3'd1;
    localparam logic [2:0] PAYLOAD = 3'd2;
    localparam logic [2:0] PAD     = 3'd3;
    localparam logic [2:0] GAP     = 3'd4;

    // Unclamped payload words, ceil(bytes/2); one extra bit so 511 bytes -> 256.
    function automatic logic [LEN_WIDTH:0] payload_words(input logic [LEN_WIDTH-1:0] len);
        logic [LEN_WIDTH:0] sum;
        sum = {1'b0, len} + {{LEN_WIDTH{1'b0}}, 1'b1};
        return sum >> 1;
    endfunction

endpackage

// File: rtl/rx_packet_reader.sv
// RX channel read engine: emits fixed PKT_WORDS-word packets (header, payload, pad).
// Optional build macro RX_PKT_STATS_EN enables the completed-packet counter.
module rx_packet_reader
    import rx_packet_reader_pkg::*;
#(
    parameter int PH_FIFO_SZ_L2 = 7
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [PH_FIFO_SZ_L2-1:0] num_packets,
    input  logic [63:0]              i_header_data,
    input  logic [15:0]              i_chan_data,
    output logic                     rd_header_en,
    output logic                     rd_data_en,
    output logic [15:0]              o_data,
    output logic                     o_valid,
    input  logic                     i_ready,
    output logic                     o_sop,
    output logic                     o_eop,
    output logic                     busy,
    output logic                     len_err,
    output logic [15:0]              pkt_count
);

    localparam logic [WCNT_W-1:0] LAST_WORD = WCNT_W'(PKT_WORDS - 1);
    localparam logic [WCNT_W-1:0] LAST_HDR  = WCNT_W'(HDR_WORDS - 1);
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(IDLE_GAP - 1);

    logic [2:0]          state;
    logic [WCNT_W-1:0]   wcnt;
    logic [WCNT_W-1:0]   plen;
    logic [GAP_W-1:0]    gap_cnt;
    logic                accept;
    logic [LEN_WIDTH:0]  plen_raw;
    logic                plen_over;
    logic [WCNT_W:0]     pay_last_idx;
    logic                last_word;

    assign plen_raw     = payload_words(i_header_data[LEN_LSB +: LEN_WIDTH]);
    assign plen_over    = plen_raw > (LEN_WIDTH+1)'(MAX_PAYLOAD_WORDS);
    assign pay_last_idx = (WCNT_W+1)'(HDR_WORDS) + {1'b0, plen} - (WCNT_W+1)'(1);
    assign last_word    = (wcnt == LAST_WORD);
    assign accept       = o_valid && i_ready;

    // Every output is a decode of the current state, so an i_ready stall
    // leaves data and qualifiers untouched without extra holding registers.
    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        o_valid      = 1'b0;
        o_data       = 16'h0;
        o_sop        = 1'b0;
        rd_header_en = 1'b0;
        rd_data_en   = 1'b0;
        case (state)
            HDR: begin
                o_valid      = 1'b1;
                o_data       = i_header_data[{wcnt[1:0], 4'b0000} +: 16];
                o_sop        = (wcnt == '0);
                rd_header_en = (wcnt == LAST_HDR) && i_ready;
            end
            PAYLOAD: begin
                o_valid    = 1'b1;
                o_data     = i_chan_data;
                rd_data_en = i_ready;
            end
            PAD: begin
                o_valid = 1'b1;
            end
            default: ;
        endcase
    end

    assign o_eop = o_valid && last_word;
    assign busy  = (state != IDLE) && (state != GAP);

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // register samples the pre-edge value of its peers.
        if (reset) begin
            state   <= IDLE;
            wcnt    <= '0;
            plen    <= '0;
            gap_cnt <= '0;
            len_err <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (num_packets != '0) begin
                        plen  <= plen_over ? WCNT_W'(MAX_PAYLOAD_WORDS) : plen_raw[WCNT_W-1:0];
                        wcnt  <= '0;
                        state <= HDR;
                        if (plen_over) len_err <= 1'b1;
                    end
                end
                HDR: begin
                    if (accept) begin
                        wcnt <= wcnt + 1'b1;
                        if (wcnt == LAST_HDR) state <= (plen != '0) ? PAYLOAD : PAD;
                    end
                end
                PAYLOAD: begin
                    if (accept) begin
                        wcnt <= wcnt + 1'b1;
                        if ({1'b0, wcnt} == pay_last_idx) begin
                            // A maximum-length payload fills the packet, so padding is skipped.
                            state   <= last_word ? GAP : PAD;
                            gap_cnt <= '0;
                        end
                    end
                end
                PAD: begin
                    if (accept) begin
                        wcnt <= wcnt + 1'b1;
                        if (last_word) begin
                            state   <= GAP;
                            gap_cnt <= '0;
                        end
                    end
                end
                GAP: begin
                    // Hold off relaunch until the header FIFO fill level reflects the pop.
                    if (gap_cnt == GAP_LAST) state   <= IDLE;
                    else                     gap_cnt <= gap_cnt + 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef RX_PKT_STATS_EN
    logic [15:0] pkt_cnt_q;

    always_ff @(posedge clk) begin
        if (reset)                 pkt_cnt_q <= 16'h0;
        else if (o_eop && accept)  pkt_cnt_q <= pkt_cnt_q + 16'h1;
    end

    assign pkt_count = pkt_cnt_q;
`else
    assign pkt_count = 16'h0;
`endif

endmodule

// File: doc/rx_packet_reader.md
Name: rx_packet_reader

Overview:
- Read-side engine for one RX channel buffer: drains the packet-header FIFO and the channel-data FIFO and emits fixed 256-word (512-byte) USB packets as a 16-bit valid/ready stream.
- Packet layout: 4 header words, then payload words, then zero padding to PKT_WORDS.
- Sits in the read-clock domain between the channel buffer (show-ahead FIFOs, read strobe = ACK) and the USB/FX2 transfer mux.

Parameters:
- PH_FIFO_SZ_L2, 7, width of num_packets (header FIFO rdusedw).
- PKT_WORDS, 256, 16-bit words per emitted packet.
- MAX_PAYLOAD_WORDS, 252, equals PKT_WORDS-4; payload clamp limit.
- LEN_LSB, 0, bit position of the byte-length field in the header.
- LEN_WIDTH, 9, width of the byte-length field.
- IDLE_GAP, 2, minimum idle cycles between packets (covers rdusedw update latency).

Ports:
- clk  in  1  read clock; all logic on posedge.
- reset  in  1  synchronous, active-high.
- num_packets  in  PH_FIFO_SZ_L2  complete packets queued (header FIFO rdusedw).
- i_header_data  in  64  header FIFO show-ahead q.
- i_chan_data  in  16  channel-data FIFO show-ahead q.
- rd_header_en  out  1  header FIFO read ACK, one-cycle pulse.
- rd_data_en  out  1  channel-data FIFO read ACK, one per payload word consumed.
- o_data  out  16  stream word.
- o_valid  out  1  o_data valid.
- i_ready  in  1  downstream accepts the word when o_valid && i_ready.
- o_sop  out  1  qualifies word 0 of a packet.
- o_eop  out  1  qualifies word PKT_WORDS-1.
- busy  out  1  high in every state except IDLE and GAP.
- len_err  out  1  sticky; set when a header length exceeds MAX_PAYLOAD_WORDS.
- pkt_count  out  16  completed-packet count (see Optional Feature).

Behaviour:
- Reset (synchronous):
  - State goes to IDLE, all counters clear.
  - All outputs 0: o_valid, o_sop, o_eop, rd_*_en, busy, len_err, pkt_count.
  - Reset mid-packet abandons the packet. FIFOs are cleared by the same system reset, so no partial ACK recovery is needed.
- "Accept" means o_valid && i_ready in the same cycle.
- States:
  - IDLE: o_valid=0. If num_packets != 0, latch the payload word count into plen and go to HDR with word index 0.
  - HDR: o_valid=1. o_data = i_header_data[16*idx+15 : 16*idx], idx 0..3 (low word first). o_sop=1 at idx 0. Each accept increments idx. On the accept at idx 3:
    - rd_header_en pulses that cycle.
    - If plen != 0, go to PAYLOAD.
    - If plen == 0, go to PAD.
  - PAYLOAD: o_valid=1. o_data = i_chan_data (combinational from show-ahead q, zero latency). rd_data_en = accept. After plen accepts, go to PAD, or to GAP if the packet is already full.
  - PAD: o_valid=1, o_data=0. Continue until the total word count reaches PKT_WORDS. o_eop=1 on the final word. After its accept, go to GAP.
  - GAP: o_valid=0 for IDLE_GAP cycles, then IDLE. This prevents re-launching on a stale num_packets.
- Payload length:
  - plen = ceil(bytes/2) = (len+1)>>1, where len = i_header_data[LEN_LSB +: LEN_WIDTH].
  - If plen > MAX_PAYLOAD_WORDS: clamp to MAX_PAYLOAD_WORDS and set len_err.
  - In the clamped case the excess channel-data words stay in the FIFO. This is a documented misalignment; recovery is by reset only.
- Word counter spans 0..PKT_WORDS-1 and needs no wrap logic. o_eop occurs exactly once per packet.
- i_ready low: o_valid, o_data and all qualifiers hold stable; no FIFO ACK is issued.
- Back-to-back packets: at 100% i_ready, a 256-word packet takes 256 active cycles + IDLE_GAP + 1 IDLE cycle.
- num_packets changing during a packet is ignored; it is sampled only in IDLE.

Optional Feature:
- Macro: RX_PKT_STATS_EN.
- Defined: pkt_count increments on each o_eop accept, wraps from 0xFFFF to 0, and clears on reset.
- Undefined: pkt_count is tied to 16'h0 and no counter logic is built. The port exists in both builds.

Decomposition:
- Shared package / inband_packet_defs: header length field position (LEN_LSB, LEN_WIDTH), PKT_WORDS, header word count (4), state encoding localparams (IDLE, HDR, PAYLOAD, PAD, GAP).
- Single module; a sub-module is not warranted. The optional stats counter is an inline generate/ifdef block.

Test Plan:
- Header len=8 bytes, 4 data words, num_packets=1, i_ready=1:
  - Output is 4 header words, 4 data words, 248 zeros.
  - o_sop on word 0, o_eop on word 255.
  - Exactly one rd_header_en pulse, exactly 4 rd_data_en pulses.
- len=504 bytes: 252 data words then o_eop, with no PAD words; len=0: 4 header words then 252 zeros, and rd_data_en never asserts.
- len=7 (odd): plen=4, so 4 data words are consumed; len=511: plen clamped to 252 and len_err=1 stays set.
- i_ready toggled pseudo-randomly every cycle: the output sequence is identical to the i_ready=1 case, and rd_data_en asserts only on accepts.
- num_packets=2 held constant through the first packet: the second packet starts after ≥IDLE_GAP idle cycles; with RX_PKT_STATS_EN, pkt_count=2.
- Reset asserted at payload word 10: next cycle all outputs are 0 and state is IDLE; after reset deasserts with num_packets=1, a fresh packet begins at header word 0.
